// File: rtl/control_sequencer.sv
// control_sequencer
// Multicycle instruction sequencer for the CPU control unit. It owns the
// program counter (counting downward), the saved ALU flags and the WAIT
// millisecond timer, and drives every datapath control line from a Moore
// state machine.
//
// Ports:
//   clk             system clock
//   reset           synchronous, active-low reset
//   instr           memory port A read data (current instruction)
//   mem_ready       memory port A access complete this cycle
//   alu_c           ALU result (jump target offset)
//   flags_in        ALU flags, latched when leaving EXEC
//   pc              program counter
//   addr_sel        1 = port A address from pc, 0 = from reg_b
//   result_sel      1 = register write data from ALU, 0 = from memory
//   alu_op_override 1 = ALU opcode from alu_op_value, 0 = from instr
//   alu_op_value    {OP_ADDI, instr[11:8], 8'h00}
//   reg_we, mem_we  register file / memory port A write enables
//   reg_write, reg_read_a, reg_read_b  register file port indices
//   saved_flags     flags from the last R/I-type execute
//   state           current state, for debug
module control_sequencer #(
   parameter int                  PC_WIDTH     = 15,
   parameter logic [PC_WIDTH-1:0] PC_RESET     = {PC_WIDTH{1'b1}},
   parameter int                  FLAG_WIDTH   = 5,
   parameter int                  TICKS_PER_MS = 33334,
   parameter int                  MS_WIDTH     = 12,
   parameter logic [3:0]          OP_JUMP      = 4'hC,
   parameter logic [3:0]          OP_LOAD      = 4'h4,
   parameter logic [3:0]          OP_STORE     = 4'h5,
   parameter logic [3:0]          OP_WAIT      = 4'hF,
   parameter logic [3:0]          OP_BRANCH    = 4'hD,
   parameter logic [3:0]          OP_ADDI      = 4'h6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [15:0]           instr,
   input  logic                  mem_ready,
   input  logic [15:0]           alu_c,
   input  logic [FLAG_WIDTH-1:0] flags_in,
   output logic [PC_WIDTH-1:0]   pc,
   output logic                  addr_sel,
   output logic                  result_sel,
   output logic                  alu_op_override,
   output logic [15:0]           alu_op_value,
   output logic                  reg_we,
   output logic                  mem_we,
   output logic [3:0]            reg_write,
   output logic [3:0]            reg_read_a,
   output logic [3:0]            reg_read_b,
   output logic [FLAG_WIDTH-1:0] saved_flags,
   output logic [3:0]            state
);

   localparam int                  TICK_W    = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
   localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(TICKS_PER_MS - 1);
   localparam logic [TICK_W-1:0]   TICK_ONE  = TICK_W'(1);
   localparam logic [MS_WIDTH-1:0] MS_ONE    = MS_WIDTH'(1);
   localparam logic [PC_WIDTH-1:0] PC_ONE    = PC_WIDTH'(1);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_EXEC   = 4'd2,
      S_JUMP   = 4'd3,
      S_LOAD1  = 4'd4,
      S_LOAD2  = 4'd5,
      S_STORE  = 4'd6,
      S_WAIT   = 4'd7,
      S_BRANCH = 4'd8
   } state_t;

   state_t                state_r;
   state_t                state_next_s;
   logic [PC_WIDTH-1:0]   pc_r;
   logic [FLAG_WIDTH-1:0] flags_r;
   logic [TICK_W-1:0]     tick_r;
   logic [MS_WIDTH-1:0]   ms_r;
   logic                  wait_match_s;
   logic                  branch_taken_s;
   logic [PC_WIDTH-1:0]   branch_off_s;
   logic                  unused_s;

   // Only the low PC_WIDTH bits of the ALU result can reach the PC.
   assign unused_s = ^alu_c;

   // WAIT completes when the elapsed millisecond count reaches the field.
   always_comb begin
      wait_match_s = (ms_r == instr[MS_WIDTH-1:0]);
   end

   // Branch condition: index 4'hF is always taken; indices beyond the flag
   // vector never are. The 8-bit offset is sign-extended to PC width.
   always_comb begin
      branch_taken_s = 1'b0;
      branch_off_s   = {{(PC_WIDTH-8){instr[7]}}, instr[7:0]};
      if (instr[11:8] == 4'hF) begin
         branch_taken_s = 1'b1;
      end else begin
         for (int i = 0; i < FLAG_WIDTH; i++) begin
            if (int'(instr[11:8]) == i) begin
               branch_taken_s = flags_r[i];
            end else begin
               branch_taken_s = branch_taken_s;
            end
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r <= S_FETCH;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         S_FETCH: begin
            if (mem_ready) state_next_s = S_DECODE;
            else           state_next_s = S_FETCH;
         end
         S_DECODE: begin
            if      (instr[15:12] == OP_JUMP)   state_next_s = S_JUMP;
            else if (instr[15:12] == OP_LOAD)   state_next_s = S_LOAD1;
            else if (instr[15:12] == OP_STORE)  state_next_s = S_STORE;
            else if (instr[15:12] == OP_WAIT)   state_next_s = S_WAIT;
            else if (instr[15:12] == OP_BRANCH) state_next_s = S_BRANCH;
            else                                state_next_s = S_EXEC;
         end
         S_LOAD1: begin
            if (mem_ready) state_next_s = S_LOAD2;
            else           state_next_s = S_LOAD1;
         end
         S_STORE: begin
            if (mem_ready) state_next_s = S_FETCH;
            else           state_next_s = S_STORE;
         end
         S_WAIT: begin
            if (wait_match_s) state_next_s = S_FETCH;
            else              state_next_s = S_WAIT;
         end
         S_EXEC, S_JUMP, S_LOAD2, S_BRANCH: state_next_s = S_FETCH;
         default: state_next_s = S_FETCH;
      endcase
   end

   // Program counter and saved flags, updated on leaving the owning state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_r    <= PC_RESET;
         flags_r <= '0;
      end else begin
         case (state_r)
            S_EXEC: begin
               pc_r    <= pc_r - PC_ONE;
               flags_r <= flags_in;
            end
            S_JUMP:  pc_r <= PC_RESET - alu_c[PC_WIDTH-1:0];
            S_LOAD2: pc_r <= pc_r - PC_ONE;
            S_STORE: begin
               if (mem_ready) pc_r <= pc_r - PC_ONE;
               else           pc_r <= pc_r;
            end
            S_BRANCH: begin
               if (branch_taken_s) pc_r <= pc_r - branch_off_s;
               else                pc_r <= pc_r - PC_ONE;
            end
            S_WAIT: begin
               if (wait_match_s) pc_r <= pc_r - PC_ONE;
               else              pc_r <= pc_r;
            end
            default: pc_r <= pc_r;
         endcase
      end
   end

   // WAIT timer: tick counter wraps every TICKS_PER_MS clocks and bumps the
   // millisecond count; both sit at zero outside WAIT.
   always_ff @(posedge clk) begin
      if (!reset) begin
         tick_r <= '0;
         ms_r   <= '0;
      end else if (state_r == S_WAIT && !wait_match_s) begin
         if (tick_r == TICK_LAST) begin
            tick_r <= '0;
            ms_r   <= ms_r + MS_ONE;
         end else begin
            tick_r <= tick_r + TICK_ONE;
         end
      end else begin
         tick_r <= '0;
         ms_r   <= '0;
      end
   end

   // Moore control decode.
   always_comb begin
      addr_sel        = 1'b1;
      result_sel      = 1'b1;
      alu_op_override = 1'b0;
      reg_we          = 1'b0;
      mem_we          = 1'b0;
      case (state_r)
         S_EXEC:  reg_we = 1'b1;
         S_JUMP:  alu_op_override = 1'b1;
         S_LOAD1: addr_sel = 1'b0;
         S_LOAD2: begin
            result_sel = 1'b0;
            reg_we     = 1'b1;
         end
         S_STORE: begin
            addr_sel        = 1'b0;
            alu_op_override = 1'b1;
            mem_we          = 1'b1;
         end
         default: addr_sel = 1'b1;
      endcase
   end

   assign alu_op_value = {OP_ADDI, instr[11:8], 8'h00};
   assign reg_write    = instr[11:8];
   assign reg_read_a   = instr[11:8];
   assign reg_read_b   = instr[3:0];
   assign pc           = pc_r;
   assign saved_flags  = flags_r;
   assign state        = state_r;

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Parametrised multicycle instruction sequencer: the next-generation CPU control unit that owns the program counter, saved ALU flags and the WAIT millisecond timer. It drives every datapath control line (memory port A address/write select, register-file ports, ALU opcode override, result mux) from a Moore state machine. New over the previous generation:
- configurable PC width, tick rate and opcode map;
- a memory-ready stall handshake;
- a working conditional BRANCH instruction.

## Interface
Parameters:
- PC_WIDTH, 15: program counter width; PC counts downward.
- PC_RESET, {PC_WIDTH{1'b1}}: PC value after reset; also the jump base.
- FLAG_WIDTH, 5: ALU flag vector width.
- TICKS_PER_MS, 33334: clocks per WAIT millisecond (≥ 1).
- MS_WIDTH, 12: WAIT count field width, instr[MS_WIDTH-1:0] (≤ 12).
- OP_JUMP 4'hC, OP_LOAD 4'h4, OP_STORE 4'h5, OP_WAIT 4'hF, OP_BRANCH 4'hD, OP_ADDI 4'h6: opcode encodings compared against instr[15:12].

Ports:
- clk, input, 1: single system clock.
- reset, input, 1: synchronous, active-low reset.
- instr, input, 16: memory port A read data, i.e. the current instruction.
- mem_ready, input, 1: memory port A access complete this cycle.
- alu_c, input, 16: ALU result.
- flags_in, input, FLAG_WIDTH: ALU flags.
- pc, output, PC_WIDTH: program counter.
- addr_sel, output, 1: 1 = port A address from pc, 0 = from reg_b.
- result_sel, output, 1: 1 = register write data from ALU, 0 = from memory.
- alu_op_override, output, 1: 1 = ALU opcode taken from alu_op_value; 0 = taken from instr.
- alu_op_value, output, 16: {OP_ADDI, instr[11:8], 8'h00}.
- reg_we, output, 1: register file write enable.
- mem_we, output, 1: memory port A write enable.
- reg_write, reg_read_a, reg_read_b, output, 4 each: instr[11:8], instr[11:8], instr[3:0].
- saved_flags, output, FLAG_WIDTH: flags latched at the last R/I-type execute; this vector is the ALU carry source.
- state, output, 4: current state, exposed for debug.

## Operation
States and encodings: FETCH 0, DECODE 1, EXEC 2, JUMP 3, LOAD1 4, LOAD2 5, STORE 6, WAIT 7, BRANCH 8.

Transitions:
- FETCH: go to DECODE when mem_ready = 1; otherwise stay.
- DECODE: dispatch on instr[15:12]:
  - OP_JUMP → JUMP
  - OP_LOAD → LOAD1
  - OP_STORE → STORE
  - OP_WAIT → WAIT
  - OP_BRANCH → BRANCH
  - anything else → EXEC
- LOAD1: go to LOAD2 when mem_ready = 1.
- STORE: go to FETCH when mem_ready = 1.
- WAIT: go to FETCH when the count matches.
- EXEC, JUMP, LOAD2, BRANCH: go to FETCH unconditionally.

Outputs are Moore-decoded from state. Defaults: addr_sel = 1, result_sel = 1, and every other control output 0. Per state:
- EXEC: reg_we = 1; saved_flags <= flags_in; pc <= pc − 1.
- JUMP: alu_op_override = 1; pc <= PC_RESET − alu_c[PC_WIDTH-1:0], modulo 2^PC_WIDTH.
- LOAD1: addr_sel = 0.
- LOAD2: result_sel = 0; reg_we = 1; pc <= pc − 1.
- STORE: addr_sel = 0; alu_op_override = 1; mem_we = 1. pc <= pc − 1 only in the cycle mem_ready = 1. mem_we stays high throughout the stall.
- BRANCH: the branch is taken when instr[11:8] == 4'hF, or when instr[11:8] < FLAG_WIDTH and saved_flags[instr[11:8]] = 1. Any other condition index is never taken.
  - Taken: pc <= pc − sign_extend(instr[7:0]), modulo 2^PC_WIDTH.
  - Not taken: pc <= pc − 1.
- WAIT: a tick counter counts 0 … TICKS_PER_MS−1. At the wrap it increments an ms counter of MS_WIDTH bits. When ms == instr[MS_WIDTH-1:0], clear both counters and set pc <= pc − 1. The counters hold 0 outside WAIT.

## Timing
- Reset (reset = 0 at a clk edge) puts state = FETCH, pc = PC_RESET, saved_flags = 0, and both wait counters to 0. This applies in any state, including mid-WAIT or mid-STORE stall. All control outputs then take the FETCH defaults.
- Latency with mem_ready held at 1:
  - R/I-type, JUMP, BRANCH, STORE: 3 cycles.
  - LOAD: 4 cycles.
  - WAIT N: 2 + (N·TICKS_PER_MS + 1) cycles; N = 0 gives 3 cycles.
- Each cycle with mem_ready = 0 in FETCH, LOAD1 or STORE adds exactly one cycle. No other state samples mem_ready.
- saved_flags changes only on the clock edge that leaves EXEC.
- pc changes only on the clock edge that leaves EXEC, JUMP, LOAD2, BRANCH, STORE (with mem_ready = 1) or WAIT (on match).
- The pc decrement wraps: 0 − 1 = {PC_WIDTH{1'b1}}.

## Test plan
- Reset then hold: reset = 0 for 2 cycles → pc = 15'h7FFF, state = 0, saved_flags = 0, and reg_we = mem_we = 0.
- R-type: instr = 16'h0312, mem_ready = 1 → EXEC on cycle 3 with reg_we = 1, reg_write = 3, reg_read_b = 2. Afterwards pc = 15'h7FFE and saved_flags = flags_in as sampled in EXEC.
- LOAD with stall: instr = 16'h4205, mem_ready low for 2 cycles in LOAD1 → addr_sel = 0 for 3 cycles, then LOAD2 with result_sel = 0 and reg_we = 1. Total 6 cycles; pc decremented once.
- JUMP: alu_c = 16'h0010 → pc = 15'h7FEF. BRANCH instr = 16'hD0FE with saved_flags[0] = 1 → pc increases by 2. With saved_flags[0] = 0 → pc decreases by 1.
- WAIT with TICKS_PER_MS = 4: instr = 16'hF003 → 13 cycles spent in WAIT. instr = 16'hF000 → 1 cycle in WAIT.
- Reset during WAIT or during a STORE stall → next cycle state = FETCH, pc = PC_RESET, counters = 0, mem_we = 0.
